vga_layer_compositor: RTL and testbench
=======================================

// Module: vga_layer_compositor
// PURPOSE
//   Parametrised successor to the fixed game-screen pixel mux: merges NUM_LAYERS text/number layer
//   colour indices, one ROM-backed sprite (car) and one solid bar into a 12-bit RGB pixel.
//   Position and palette registers are double-buffered and commit only at frame start, so no
//   mid-frame tearing. Sits between the text_display/num_display instances and the VGA timing out.
// PARAMETERS
//   NUM_LAYERS   8    number of colour-index layers merged by priority
//   IDX_W        3    colour-index width per layer (palette depth = 2**IDX_W)
//   SPR_W        48   sprite width in pixels (x extent)
//   SPR_H        80   sprite height in pixels (y extent); ROM is column-major, addr = dx*SPR_H+dy
//   ROM_LAT      1    sprite ROM read latency in pix_en ticks (1..3)
//   VRES         480  first non-visible line; commit point is (vgax==0, vgay==VRES)
// PORTS
//   clk          in   1                 system clock (100 MHz)
//   rst          in   1                 asynchronous, active-high reset
//   pix_en       in   1                 pixel-rate enable (1 of 4 clk); all state advances only here
//   valid        in   1                 VGA active-video flag for current vgax/vgay
//   vgax, vgay   in   10 each           current pixel coordinate
//   layer_idx    in   NUM_LAYERS*IDX_W  packed per-layer colour index, layer i at [i*IDX_W +: IDX_W]
//   cfg_we       in   1                 config write strobe (sampled on clk, independent of pix_en)
//   cfg_addr     in   4                 0 spr_x, 1 spr_y, 2 bar_x, 3 bar_y0, 4 bar_y1, 8..15 palette[0..7]
//   cfg_data     in   12                write data (positions use [9:0])
//   spr_addr     out  12                sprite ROM address
//   spr_data     in   12                sprite ROM data, valid ROM_LAT pix_en ticks after spr_addr
//   frame_commit out  1                 one-clk pulse when shadow->active copy happens
//   pixel        out  12                registered RGB output
// BEHAVIOUR
//   - Reset: pixel=0, spr_addr=0, frame_commit=0; spr_x=200, spr_y=80, bar_x=252, bar_y0=75,
//     bar_y1=565; palette = FFF,0FF,F00,0F0,000,00F,00F,00F; shadow and active both reset.
//   - Config: cfg_we writes shadow only; unmapped addrs (5..7) ignored. Active copy taken on the
//     pix_en tick where vgax==0 && vgay==VRES; same-clk write+commit: active gets pre-write shadow,
//     shadow keeps new data (visible next frame). frame_commit pulses on that clk.
//   - Pipeline (pix_en ticks): S0 register coords, valid, layer_idx, window hits; S0 drives spr_addr.
//     Sideband delayed ROM_LAT ticks to meet spr_data; final stage registers pixel.
//     Total latency = ROM_LAT+1 pix_en ticks from coordinate to pixel; constant, no bubbles.
//   - Window tests on 11-bit zero-extended sums (no wrap): in_spr = x>=spr_x && x<spr_x+SPR_W &&
//     y>=spr_y && y<spr_y+SPR_H; spr_x near 1023 -> sprite clipped, never aliased to x=0.
//   - in_bar = x>=bar_x && x<bar_x+4 && y>=bar_y0 && y<bar_y1; bar_y1<=bar_y0 -> bar disabled.
//   - Priority: valid=0 -> 0; else in_spr && spr_data!=F0F -> spr_data (F0F = transparent);
//     else in_bar -> FF0; else palette[max over layers of layer_idx] (highest index wins).
//   - spr_addr = in_spr ? (x-spr_x)*SPR_H + (y-spr_y) : 0; product truncated to 12 bits.
//   - pix_en low: every register holds, incl. pixel. Reset mid-frame: outputs 0 immediately,
//     next commit occurs at the next VRES line, active regs hold reset defaults until then.
// STRUCTURE
//   vga_pkg: cfg address localparams, reset-default positions, default palette, TRANSPARENT=12'hF0F,
//     BAR_COLOR=12'hFF0, BAR_W=4.
//   Sub-module priority_max_tree #(N, W): pure combinational balanced max reduction over packed
//     bus; replaces the fixed 8-input find_max and handles non-power-of-two N by padding with 0.
//   Top holds shadow/active regs, window compare, delay line (generate over ROM_LAT), output mux.
// TESTING
//   1 Reset: rst=1 mid-line -> pixel=000 same cycle; after release with all layer_idx=0,
//     valid=1 -> pixel=FFF after ROM_LAT+1 ticks.
//   2 Priority: layer3=2, layer5=4, rest 0, outside sprite/bar -> pixel=000 (palette[4]);
//     write palette[4]=ABC, pixel stays 000 until frame_commit, then ABC.
//   3 Sprite: spr_x=200, spr_y=80, probe (210,90) -> spr_addr=10*80+10=810; ROM returns 123
//     -> pixel=123; ROM returns F0F -> layer colour shown instead.
//   4 Clip: spr_x=1000, probe x=1020 in range -> sprite drawn; probe x=5 -> not sprite.
//   5 Commit race: cfg_we spr_y=300 on the commit clk -> this frame uses old spr_y,
//     next frame frame_commit applies 300.
//   6 Blanking/enable: valid=0 -> pixel=000; pix_en held low 10 clk -> pixel and spr_addr unchanged.

Source files
------------

// File: rtl/vga_layer_compositor_pkg.sv
// rtl/vga_layer_compositor_pkg.sv - shared constants and types for the VGA layer compositor
package vga_layer_compositor_pkg;

    localparam logic [3:0] CFG_SPR_X  = 4'd0;
    localparam logic [3:0] CFG_SPR_Y  = 4'd1;
    localparam logic [3:0] CFG_BAR_X  = 4'd2;
    localparam logic [3:0] CFG_BAR_Y0 = 4'd3;
    localparam logic [3:0] CFG_BAR_Y1 = 4'd4;

    localparam logic [11:0] TRANSPARENT = 12'hF0F;
    localparam logic [11:0] BAR_COLOR   = 12'hFF0;
    localparam int          BAR_W       = 4;

    typedef struct packed {
        logic [9:0] spr_x;
        logic [9:0] spr_y;
        logic [9:0] bar_x;
        logic [9:0] bar_y0;
        logic [9:0] bar_y1;
    } pos_regs_t;

    localparam pos_regs_t POS_RESET = '{
        spr_x:  10'd200,
        spr_y:  10'd80,
        bar_x:  10'd252,
        bar_y0: 10'd75,
        bar_y1: 10'd565
    };

    function automatic logic [11:0] default_palette(input int idx);
        case (idx)
            0:       default_palette = 12'hFFF;
            1:       default_palette = 12'h0FF;
            2:       default_palette = 12'hF00;
            3:       default_palette = 12'h0F0;
            4:       default_palette = 12'h000;
            5, 6, 7: default_palette = 12'h00F;
            default: default_palette = 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/vga_layer_compositor_max_tree.sv
// rtl/vga_layer_compositor_max_tree.sv - balanced combinational max reduction over a packed bus
module priority_max_tree #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   max_out
);

    localparam int LEVELS = (N <= 1) ? 0 : $clog2(N);
    localparam int P      = 1 << LEVELS;

    // Heap-ordered tree: leaves at P-1..2P-2, unused leaves padded with zero.
    logic [P*W-1:0] padded;
    logic [W-1:0]   node [0:2*P-2];

    always_comb begin
        padded = '0;
        padded[N*W-1:0] = din;
        for (int i = 0; i < P; i++) begin
            node[P-1+i] = padded[i*W +: W];
        end
        for (int i = P - 2; i >= 0; i--) begin
            node[i] = (node[2*i+1] > node[2*i+2]) ? node[2*i+1] : node[2*i+2];
        end
    end

    assign max_out = node[0];

endmodule

// File: rtl/vga_layer_compositor.sv
// rtl/vga_layer_compositor.sv - merges colour-index layers, a ROM sprite and a bar into 12-bit RGB
module vga_layer_compositor
    import vga_layer_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int IDX_W      = 3,
    parameter int SPR_W      = 48,
    parameter int SPR_H      = 80,
    parameter int ROM_LAT    = 1,
    parameter int VRES       = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_en,
    input  logic                        valid,
    input  logic [9:0]                  vgax,
    input  logic [9:0]                  vgay,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        cfg_we,
    input  logic [3:0]                  cfg_addr,
    input  logic [11:0]                 cfg_data,
    output logic [11:0]                 spr_addr,
    input  logic [11:0]                 spr_data,
    output logic                        frame_commit,
    output logic [11:0]                 pixel
);

    localparam int PAL_N = 1 << IDX_W;
    localparam int LAST  = ROM_LAT - 1;

    pos_regs_t   shadow_pos, active_pos;
    logic [11:0] shadow_pal [PAL_N];
    logic [11:0] active_pal [PAL_N];

    logic             commit_hit;
    logic [IDX_W-1:0] pal_wr_idx;
    logic             pal_wr_ok;

    assign commit_hit = pix_en && (vgax == 10'd0) && (vgay == 10'(VRES));
    assign pal_wr_idx = IDX_W'(cfg_addr[2:0]);
    assign pal_wr_ok  = cfg_addr[3] && (int'(cfg_addr[2:0]) < PAL_N);

    // Shadow takes writes any clk; active copies the pre-write shadow on the commit tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_pos   <= POS_RESET;
            active_pos   <= POS_RESET;
            frame_commit <= 1'b0;
            for (int i = 0; i < PAL_N; i++) begin
                shadow_pal[i] <= default_palette(i);
                active_pal[i] <= default_palette(i);
            end
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_SPR_X:  shadow_pos.spr_x  <= cfg_data[9:0];
                    CFG_SPR_Y:  shadow_pos.spr_y  <= cfg_data[9:0];
                    CFG_BAR_X:  shadow_pos.bar_x  <= cfg_data[9:0];
                    CFG_BAR_Y0: shadow_pos.bar_y0 <= cfg_data[9:0];
                    CFG_BAR_Y1: shadow_pos.bar_y1 <= cfg_data[9:0];
                    default: begin
                        if (pal_wr_ok) begin
                            shadow_pal[pal_wr_idx] <= cfg_data;
                        end
                    end
                endcase
            end
            if (commit_hit) begin
                active_pos <= shadow_pos;
                active_pal <= shadow_pal;
            end
            frame_commit <= commit_hit;
        end
    end

    // Window compares widened to 11 bits so a sprite near x=1023 clips rather than wraps.
    logic [10:0] x_ext, y_ext;
    logic        hit_spr, hit_bar;
    logic [9:0]  dx, dy;
    logic [11:0] next_addr;
    logic [IDX_W-1:0] max_idx;

    assign x_ext = {1'b0, vgax};
    assign y_ext = {1'b0, vgay};

    assign hit_spr = (x_ext >= {1'b0, active_pos.spr_x})
                  && (x_ext <  {1'b0, active_pos.spr_x} + 11'(SPR_W))
                  && (y_ext >= {1'b0, active_pos.spr_y})
                  && (y_ext <  {1'b0, active_pos.spr_y} + 11'(SPR_H));

    assign hit_bar = (x_ext >= {1'b0, active_pos.bar_x})
                  && (x_ext <  {1'b0, active_pos.bar_x} + 11'(BAR_W))
                  && (y_ext >= {1'b0, active_pos.bar_y0})
                  && (y_ext <  {1'b0, active_pos.bar_y1});

    assign dx        = vgax - active_pos.spr_x;
    assign dy        = vgay - active_pos.spr_y;
    assign next_addr = hit_spr ? (12'(dx) * 12'(SPR_H) + 12'(dy)) : 12'd0;

    priority_max_tree #(
        .N (NUM_LAYERS),
        .W (IDX_W)
    ) u_max_tree (
        .din     (layer_idx),
        .max_out (max_idx)
    );

    // Stage 0 captures the sideband; stages 1..ROM_LAT-1 align it with spr_data.
    logic             sb_valid [ROM_LAT];
    logic             sb_spr   [ROM_LAT];
    logic             sb_bar   [ROM_LAT];
    logic [IDX_W-1:0] sb_idx   [ROM_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_addr <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                sb_valid[i] <= 1'b0;
                sb_spr[i]   <= 1'b0;
                sb_bar[i]   <= 1'b0;
                sb_idx[i]   <= '0;
            end
        end else if (pix_en) begin
            spr_addr    <= next_addr;
            sb_valid[0] <= valid;
            sb_spr[0]   <= hit_spr;
            sb_bar[0]   <= hit_bar;
            sb_idx[0]   <= max_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_spr[i]   <= sb_spr[i-1];
                sb_bar[i]   <= sb_bar[i-1];
                sb_idx[i]   <= sb_idx[i-1];
            end
        end
    end

    logic [11:0] pixel_next;

    always_comb begin
        pixel_next = active_pal[sb_idx[LAST]];
        if (!sb_valid[LAST]) begin
            pixel_next = 12'h000;
        end else if (sb_spr[LAST] && (spr_data != TRANSPARENT)) begin
            pixel_next = spr_data;
        end else if (sb_bar[LAST]) begin
            pixel_next = BAR_COLOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel <= '0;
        end else if (pix_en) begin
            pixel <= pixel_next;
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb/tb_vga_layer_compositor.sv - directed self-checking bench for vga_layer_compositor
module tb_vga_layer_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        valid;
    logic [9:0]  vgax, vgay;
    logic [23:0] layer_idx;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic [11:0] spr_addr;
    logic [11:0] spr_data;
    logic        frame_commit;
    logic [11:0] pixel;

    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    logic pix_run = 1'b1;
    logic [1:0] div = 2'd0;

    vga_layer_compositor dut (
        .clk          (clk),
        .rst          (rst),
        .pix_en       (pix_en),
        .valid        (valid),
        .vgax         (vgax),
        .vgay         (vgay),
        .layer_idx    (layer_idx),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .spr_addr     (spr_addr),
        .spr_data     (spr_data),
        .frame_commit (frame_commit),
        .pixel        (pixel)
    );

    always #5 clk = ~clk;

    // Pixel enable: one clk in four, updated shortly after each rising edge.
    initial begin
        pix_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            div    = div + 2'd1;
            pix_en = pix_run && (div == 2'd0);
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!pix_en) @(posedge clk);
        end
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic do_commit(input string tag);
        logic [9:0] sx, sy;
        logic       sv;
        bit         seen;
        sx = vgax; sy = vgay; sv = valid;
        seen = 1'b0;
        vgax = 10'd0; vgay = 10'd480; valid = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (frame_commit) seen = 1'b1;
        end
        vgax = sx; vgay = sy; valid = sv;
        chk(tag, 16'(seen), 16'd1);
        @(negedge clk);
        chk({tag, "_one_clk"}, 16'(frame_commit), 16'd0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; vgax = 10'd10; vgay = 10'd10;
        layer_idx = 24'h0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 12'd0;
        spr_data = 12'h000;

        #23;
        chk("rst_pixel", 16'(pixel), 16'h000);
        chk("rst_spr_addr", 16'(spr_addr), 16'd0);
        chk("rst_commit", 16'(frame_commit), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        tick(2);
        chk("idle_pal0", 16'(pixel), 16'hFFF);

        vgax = 10'd210; vgay = 10'd90; spr_data = 12'h123;
        tick(1);
        chk("spr_addr_810", 16'(spr_addr), 16'd810);
        chk("latency_not_early", 16'(pixel), 16'hFFF);
        tick(1);
        chk("spr_opaque", 16'(pixel), 16'h123);
        spr_data = 12'hF0F;
        tick(1);
        chk("spr_transparent", 16'(pixel), 16'hFFF);

        vgax = 10'd10; vgay = 10'd10; layer_idx = 24'h020400;
        tick(2);
        chk("prio_max4", 16'(pixel), 16'h000);
        layer_idx = 24'h400000;
        tick(2);
        chk("prio_l7_2", 16'(pixel), 16'hF00);
        layer_idx = 24'h000001;
        tick(2);
        chk("prio_l0_1", 16'(pixel), 16'h0FF);

        layer_idx = 24'h0;
        vgax = 10'd253; vgay = 10'd200;
        tick(2);
        chk("bar_in", 16'(pixel), 16'hFF0);
        vgax = 10'd256;
        tick(2);
        chk("bar_x_edge", 16'(pixel), 16'hFFF);
        vgax = 10'd253; vgay = 10'd565;
        tick(2);
        chk("bar_y1_edge", 16'(pixel), 16'hFFF);

        vgax = 10'd10; vgay = 10'd10; layer_idx = 24'h020400;
        cfg_write(4'd12, 12'hABC);
        tick(2);
        chk("pal_pre_commit", 16'(pixel), 16'h000);
        do_commit("commit_pal");
        tick(2);
        chk("pal_post_commit", 16'(pixel), 16'hABC);

        cfg_write(4'd0, 12'd1000);
        do_commit("commit_clip");
        vgax = 10'd1020; vgay = 10'd90; spr_data = 12'h123;
        tick(1);
        chk("clip_addr", 16'(spr_addr), 16'd1610);
        tick(1);
        chk("clip_drawn", 16'(pixel), 16'h123);
        vgax = 10'd5;
        tick(1);
        chk("clip_no_alias_addr", 16'(spr_addr), 16'd0);
        tick(1);
        chk("clip_no_alias_pix", 16'(pixel), 16'hABC);

        vgax = 10'd0; vgay = 10'd480; valid = 1'b0;
        @(negedge clk);
        while (!pix_en) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 12'd300;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("race_commit", 16'(frame_commit), 16'd1);
        vgax = 10'd1020; vgay = 10'd90; valid = 1'b1;
        tick(1);
        chk("race_old_spr_y", 16'(spr_addr), 16'd1610);
        do_commit("commit_race");
        tick(1);
        chk("race_new_out", 16'(spr_addr), 16'd0);
        vgay = 10'd310;
        tick(1);
        chk("race_new_in", 16'(spr_addr), 16'd1610);

        valid = 1'b0;
        tick(2);
        chk("blank", 16'(pixel), 16'h000);
        valid = 1'b1;
        tick(2);
        chk("unblank", 16'(pixel), 16'h123);

        pix_run = 1'b0;
        @(posedge clk); #3;
        vgax = 10'd10; vgay = 10'd10; spr_data = 12'hF0F; valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_pixel", 16'(pixel), 16'h123);
        chk("hold_spr_addr", 16'(spr_addr), 16'd1610);
        pix_run = 1'b1;
        valid = 1'b1;
        tick(2);

        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pixel", 16'(pixel), 16'h000);
        chk("midrst_spr_addr", 16'(spr_addr), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk("midrst_pal4_default", 16'(pixel), 16'h000);
        layer_idx = 24'h0;
        tick(2);
        chk("midrst_pal0", 16'(pixel), 16'hFFF);
        vgax = 10'd210; vgay = 10'd90;
        tick(1);
        chk("midrst_spr_default", 16'(spr_addr), 16'd810);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
